itch_msg_parser: RTL and testbench

- Consumes the ITCH payload byte stream (MoldUDP64 message blocks) produced by eth_udp_parser in the 250 MHz domain.
- Frames each message block from its 2-byte big-endian length.
- Decodes ITCH 5.0 Add Order ('A', 0x41) and Order Delete ('D', 0x44) into parallel fields for the downstream order book; all other types are skipped.
- Sits between eth_udp_parser and the future book-update stage.

---
 rtl/itch_pkg.sv | 79 +++++++
 rtl/itch_msg_parser.sv | 142 ++++++++++++++
 tb/tb_itch_msg_parser.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/itch_pkg.sv
// Shared ITCH 5.0 definitions: message codes, body field offsets, FSM states
// and the decoded-message record that the book stage also consumes.
package itch_pkg;

    localparam logic [7:0] MSG_ADD  = 8'h41;
    localparam logic [7:0] MSG_DEL  = 8'h44;
    localparam logic [7:0] SIDE_BUY = 8'h42;

    localparam int ADD_LEN_DEF = 36;
    localparam int DEL_LEN_DEF = 19;

    localparam logic [15:0] OFF_TYPE   = 16'd0;
    localparam logic [15:0] OFF_LOCATE = 16'd1;
    localparam logic [15:0] OFF_TRACK  = 16'd3;
    localparam logic [15:0] OFF_TS     = 16'd5;
    localparam logic [15:0] OFF_REF    = 16'd11;
    localparam logic [15:0] OFF_SIDE   = 16'd19;
    localparam logic [15:0] OFF_SHARES = 16'd20;
    localparam logic [15:0] OFF_STOCK  = 16'd24;
    localparam logic [15:0] OFF_PRICE  = 16'd32;
    localparam logic [15:0] OFF_END    = 16'd36;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_BODY,
        ST_SKIP
    } parser_state_e;

    typedef struct packed {
        logic [7:0]  msgType;
        logic [15:0] locate;
        logic [47:0] timestamp;
        logic [63:0] orderRef;
        logic        side;
        logic [31:0] shares;
        logic [63:0] stock;
        logic [31:0] price;
    } itch_msg_t;

    // Shifts one body byte into whichever field owns offset idx; tracking bytes are dropped.
    function automatic itch_msg_t captureByte(input itch_msg_t cur, input logic [15:0] idx,
                                              input logic [7:0] b);
        itch_msg_t m;
        m = cur;
        if (idx == OFF_TYPE)
            m.msgType = b;
        else if (idx >= OFF_LOCATE && idx < OFF_TRACK)
            m.locate = {m.locate[7:0], b};
        else if (idx >= OFF_TS && idx < OFF_REF)
            m.timestamp = {m.timestamp[39:0], b};
        else if (idx >= OFF_REF && idx < OFF_SIDE)
            m.orderRef = {m.orderRef[55:0], b};
        else if (idx == OFF_SIDE)
            m.side = (b == SIDE_BUY);
        else if (idx >= OFF_SHARES && idx < OFF_STOCK)
            m.shares = {m.shares[23:0], b};
        else if (idx >= OFF_STOCK && idx < OFF_PRICE)
            m.stock = {m.stock[55:0], b};
        else if (idx >= OFF_PRICE && idx < OFF_END)
            m.price = {m.price[23:0], b};
        return m;
    endfunction

    // Delete carries no side/shares/stock/price; clear whatever an earlier Add left behind.
    function automatic itch_msg_t finalizeMsg(input itch_msg_t cur);
        itch_msg_t m;
        m = cur;
        if (cur.msgType == MSG_DEL) begin
            m.side   = 1'b0;
            m.shares = '0;
            m.stock  = '0;
            m.price  = '0;
        end
        return m;
    endfunction

endpackage

// File: rtl/itch_msg_parser.sv
// Frames MoldUDP64 message blocks from the payload byte stream and decodes
// ITCH Add Order / Order Delete into parallel fields for the order book.
//
// state   | meaning
// IDLE    | waiting for a packet start (sop byte = length high)
// LEN_HI  | expecting length high byte of the next message block
// LEN_LO  | expecting length low byte
// BODY    | type byte, then field capture of a decodable Add/Delete
// SKIP    | discarding body bytes of an unsupported or malformed message
module itch_msg_parser
    import itch_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int ADD_LEN = ADD_LEN_DEF,
    parameter int DEL_LEN = DEL_LEN_DEF
) (
    input  logic        clkIn,
    input  logic        rstBIn,
    input  logic        dataValidIn,
    input  logic [7:0]  dataIn,
    input  logic        sopIn,
    input  logic        packetLostIn,
    output logic        msgValidOut,
    output logic [7:0]  msgTypeOut,
    output logic [15:0] locateOut,
    output logic [47:0] timestampOut,
    output logic [63:0] orderRefOut,
    output logic        sideOut,
    output logic [31:0] sharesOut,
    output logic [63:0] stockOut,
    output logic [31:0] priceOut,
    output logic        malformedOut
);

    parser_state_e    state, stateNext;
    logic [LEN_W-1:0] lenReg, lenNext, lenLo, lenMinus1;
    logic [LEN_W-1:0] idx, idxNext;
    itch_msg_t        cap, capNext, msgOut;
    logic             msgValidNext, malformedNext, loadOut;
    logic             isAdd, isDel;

    assign lenMinus1 = lenReg - LEN_W'(1);
    assign isAdd     = (dataIn == MSG_ADD);
    assign isDel     = (dataIn == MSG_DEL);

    always_ff @(posedge clkIn or negedge rstBIn) begin
        if (!rstBIn) begin
            state        <= ST_IDLE;
            lenReg       <= '0;
            idx          <= '0;
            cap          <= '0;
            msgOut       <= '0;
            msgValidOut  <= 1'b0;
            malformedOut <= 1'b0;
        end else begin
            state        <= stateNext;
            lenReg       <= lenNext;
            idx          <= idxNext;
            cap          <= capNext;
            msgValidOut  <= msgValidNext;
            malformedOut <= malformedNext;
            if (loadOut)
                msgOut <= finalizeMsg(capNext);
        end
    end

    always_comb begin
        stateNext     = state;
        lenNext       = lenReg;
        idxNext       = idx;
        capNext       = cap;
        msgValidNext  = 1'b0;
        malformedNext = 1'b0;
        loadOut       = 1'b0;
        lenLo         = {lenReg[LEN_W-1:8], dataIn};

        if (packetLostIn) begin
            stateNext = ST_IDLE;
        end else if (dataValidIn) begin
            // A sop mid-message aborts it; the sop byte itself starts the new block.
            if (sopIn && (state == ST_LEN_LO || state == ST_BODY || state == ST_SKIP)) begin
                malformedNext = 1'b1;
                lenNext       = LEN_W'({dataIn, 8'h00});
                stateNext     = ST_LEN_LO;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sopIn) begin
                            lenNext   = LEN_W'({dataIn, 8'h00});
                            stateNext = ST_LEN_LO;
                        end
                    end
                    ST_LEN_HI: begin
                        lenNext   = LEN_W'({dataIn, 8'h00});
                        stateNext = ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        lenNext   = lenLo;
                        idxNext   = '0;
                        stateNext = (lenLo == '0) ? ST_LEN_HI : ST_BODY;
                    end
                    ST_BODY: begin
                        capNext = captureByte(cap, 16'(idx), dataIn);
                        if (idx == '0) begin
                            if ((isAdd && lenReg == LEN_W'(ADD_LEN)) ||
                                (isDel && lenReg == LEN_W'(DEL_LEN))) begin
                                idxNext = idx + LEN_W'(1);
                            end else begin
                                malformedNext = isAdd || isDel;
                                idxNext       = idx + LEN_W'(1);
                                stateNext     = (lenMinus1 == '0) ? ST_LEN_HI : ST_SKIP;
                            end
                        end else if (idx == lenMinus1) begin
                            loadOut      = 1'b1;
                            msgValidNext = 1'b1;
                            stateNext    = ST_LEN_HI;
                        end else begin
                            idxNext = idx + LEN_W'(1);
                        end
                    end
                    ST_SKIP: begin
                        if (idx == lenMinus1)
                            stateNext = ST_LEN_HI;
                        else
                            idxNext = idx + LEN_W'(1);
                    end
                    default: stateNext = ST_IDLE;
                endcase
            end
        end
    end

    assign msgTypeOut   = msgOut.msgType;
    assign locateOut    = msgOut.locate;
    assign timestampOut = msgOut.timestamp;
    assign orderRefOut  = msgOut.orderRef;
    assign sideOut      = msgOut.side;
    assign sharesOut    = msgOut.shares;
    assign stockOut     = msgOut.stock;
    assign priceOut     = msgOut.price;

endmodule

// File: tb/tb_itch_msg_parser.sv
// Directed bench for itch_msg_parser: byte streams built from hand-written
// messages, with expected fields written out as constants.
module tb_itch_msg_parser;

    logic        clkIn = 1'b0;
    logic        rstBIn = 1'b0;
    logic        dataValidIn = 1'b0;
    logic [7:0]  dataIn = 8'h00;
    logic        sopIn = 1'b0;
    logic        packetLostIn = 1'b0;
    logic        msgValidOut;
    logic [7:0]  msgTypeOut;
    logic [15:0] locateOut;
    logic [47:0] timestampOut;
    logic [63:0] orderRefOut;
    logic        sideOut;
    logic [31:0] sharesOut;
    logic [63:0] stockOut;
    logic [31:0] priceOut;
    logic        malformedOut;

    itch_msg_parser dut (
        .clkIn(clkIn), .rstBIn(rstBIn), .dataValidIn(dataValidIn), .dataIn(dataIn),
        .sopIn(sopIn), .packetLostIn(packetLostIn), .msgValidOut(msgValidOut),
        .msgTypeOut(msgTypeOut), .locateOut(locateOut), .timestampOut(timestampOut),
        .orderRefOut(orderRefOut), .sideOut(sideOut), .sharesOut(sharesOut),
        .stockOut(stockOut), .priceOut(priceOut), .malformedOut(malformedOut)
    );

    always #2 clkIn = ~clkIn;

    localparam logic [63:0] STOCK_AAPL = 64'h4141504C20202020;

    int cyc = 0;
    always @(posedge clkIn) cyc <= cyc + 1;

    int validCount = 0;
    int malCount = 0;
    int bothCount = 0;
    int pulseCyc = -1;
    int lastCyc = 0;
    logic [7:0] prevType = 8'h00;
    logic [7:0] curType = 8'h00;

    always @(negedge clkIn) begin
        if (msgValidOut) begin
            validCount = validCount + 1;
            pulseCyc   = cyc;
            prevType   = curType;
            curType    = msgTypeOut;
        end
        if (malformedOut) malCount = malCount + 1;
        if (msgValidOut && malformedOut) bothCount = bothCount + 1;
    end

    int total = 0;
    int passed = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            passed = passed + 1;
    endtask

    logic [7:0] sb[$];
    bit         ss[$];

    task automatic pushByte(input logic [7:0] b, input bit s);
        sb.push_back(b);
        ss.push_back(s);
    endtask

    task automatic pushField(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) pushByte(v[8*i +: 8], 1'b0);
    endtask

    task automatic pushAdd(input bit s, input logic [15:0] loc, input logic [47:0] ts,
                           input logic [63:0] oref, input logic [7:0] side,
                           input logic [31:0] shares, input logic [63:0] stock,
                           input logic [31:0] price);
        pushByte(8'h00, s);
        pushByte(8'h24, 1'b0);
        pushByte(8'h41, 1'b0);
        pushField(64'(loc), 2);
        pushField(64'hABCD, 2);
        pushField(64'(ts), 6);
        pushField(oref, 8);
        pushByte(side, 1'b0);
        pushField(64'(shares), 4);
        pushField(stock, 8);
        pushField(64'(price), 4);
    endtask

    task automatic pushDel(input bit s, input logic [15:0] loc, input logic [47:0] ts,
                           input logic [63:0] oref);
        pushByte(8'h00, s);
        pushByte(8'h13, 1'b0);
        pushByte(8'h44, 1'b0);
        pushField(64'(loc), 2);
        pushField(64'h1357, 2);
        pushField(64'(ts), 6);
        pushField(oref, 8);
    endtask

    task automatic dropTail(input int n);
        repeat (n) begin
            void'(sb.pop_back());
            void'(ss.pop_back());
        end
    endtask

    task automatic idleCycle();
        @(negedge clkIn);
        dataValidIn  = 1'b0;
        sopIn        = 1'b0;
        packetLostIn = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) idleCycle();
        #1;
    endtask

    task automatic playStream(input bit gaps);
        while (sb.size() > 0) begin
            if (gaps && $urandom_range(0, 1) == 1) idleCycle();
            @(negedge clkIn);
            dataValidIn  = 1'b1;
            dataIn       = sb.pop_front();
            sopIn        = ss.pop_front();
            packetLostIn = 1'b0;
            lastCyc      = cyc + 1;
        end
        settle(3);
    endtask

    task automatic checkFields(input string tag, input logic [7:0] typ, input logic [15:0] loc,
                               input logic [47:0] ts, input logic [63:0] oref, input logic side,
                               input logic [31:0] shares, input logic [63:0] stock,
                               input logic [31:0] price);
        checkVal({tag, "_type"}, 64'(msgTypeOut), 64'(typ));
        checkVal({tag, "_locate"}, 64'(locateOut), 64'(loc));
        checkVal({tag, "_ts"}, 64'(timestampOut), 64'(ts));
        checkVal({tag, "_ref"}, orderRefOut, oref);
        checkVal({tag, "_side"}, 64'(sideOut), 64'(side));
        checkVal({tag, "_shares"}, 64'(sharesOut), 64'(shares));
        checkVal({tag, "_stock"}, stockOut, stock);
        checkVal({tag, "_price"}, 64'(priceOut), 64'(price));
    endtask

    int v0, m0;

    initial begin
        repeat (3) @(negedge clkIn);
        #1;
        checkVal("rst_valid", 64'(msgValidOut), 64'd0);
        checkVal("rst_malformed", 64'(malformedOut), 64'd0);
        checkVal("rst_ref", orderRefOut, 64'd0);
        checkVal("rst_type", 64'(msgTypeOut), 64'd0);
        @(negedge clkIn);
        rstBIn = 1'b1;
        settle(2);

        // Single Add order
        v0 = validCount; m0 = malCount;
        pushAdd(1'b1, 16'h0001, 48'h000012345678, 64'h1122334455667788, 8'h42,
                32'd100, STOCK_AAPL, 32'd1500000);
        playStream(1'b0);
        checkVal("add_pulses", 64'(validCount - v0), 64'd1);
        checkVal("add_malformed", 64'(malCount - m0), 64'd0);
        checkVal("add_latency", 64'(pulseCyc), 64'(lastCyc));
        checkFields("add", 8'h41, 16'h0001, 48'h000012345678, 64'h1122334455667788, 1'b1,
                    32'h00000064, STOCK_AAPL, 32'h0016E360);
        settle(4);
        checkVal("add_hold_valid", 64'(msgValidOut), 64'd0);
        checkVal("add_hold_ref", orderRefOut, 64'h1122334455667788);

        // Add then Delete back to back
        v0 = validCount;
        pushAdd(1'b1, 16'h0001, 48'h000012345678, 64'h1122334455667788, 8'h42,
                32'd100, STOCK_AAPL, 32'd1500000);
        pushDel(1'b0, 16'h0002, 48'h0000AABBCCDD, 64'hDEADBEEF00000001);
        playStream(1'b0);
        checkVal("adddel_pulses", 64'(validCount - v0), 64'd2);
        checkVal("adddel_first_type", 64'(prevType), 64'h41);
        checkFields("del", 8'h44, 16'h0002, 48'h0000AABBCCDD, 64'hDEADBEEF00000001, 1'b0,
                    32'd0, 64'd0, 32'd0);

        // Add with random valid gaps
        v0 = validCount;
        pushAdd(1'b1, 16'h0001, 48'h000012345678, 64'h1122334455667788, 8'h42,
                32'd100, STOCK_AAPL, 32'd1500000);
        playStream(1'b1);
        checkVal("gap_pulses", 64'(validCount - v0), 64'd1);
        checkVal("gap_latency", 64'(pulseCyc), 64'(lastCyc));
        checkFields("gap", 8'h41, 16'h0001, 48'h000012345678, 64'h1122334455667788, 1'b1,
                    32'h00000064, STOCK_AAPL, 32'h0016E360);

        // Unknown type skipped, then Add
        v0 = validCount; m0 = malCount;
        pushByte(8'h00, 1'b1);
        pushByte(8'h0C, 1'b0);
        pushByte(8'h53, 1'b0);
        repeat (11) pushByte(8'h41, 1'b0);
        pushAdd(1'b0, 16'h0042, 48'h000000000777, 64'h0A0B0C0D0E0F1011, 8'h53,
                32'd250, 64'h4D53465420202020, 32'd987654);
        playStream(1'b0);
        checkVal("skip_pulses", 64'(validCount - v0), 64'd1);
        checkVal("skip_malformed", 64'(malCount - m0), 64'd0);
        checkFields("skipadd", 8'h41, 16'h0042, 48'h000000000777, 64'h0A0B0C0D0E0F1011, 1'b0,
                    32'd250, 64'h4D53465420202020, 32'd987654);

        // Add with wrong length (35) then Delete
        v0 = validCount; m0 = malCount;
        pushByte(8'h00, 1'b1);
        pushByte(8'h23, 1'b0);
        pushByte(8'h41, 1'b0);
        repeat (34) pushByte(8'h00, 1'b0);
        pushDel(1'b0, 16'h0003, 48'h000000000001, 64'h00000000000000FF);
        playStream(1'b0);
        checkVal("badlen_malformed", 64'(malCount - m0), 64'd1);
        checkVal("badlen_pulses", 64'(validCount - v0), 64'd1);
        checkVal("badlen_next_type", 64'(msgTypeOut), 64'h44);
        checkVal("badlen_next_ref", orderRefOut, 64'h00000000000000FF);

        // sop arriving at body byte 20 of an Add
        v0 = validCount; m0 = malCount;
        pushAdd(1'b1, 16'h0009, 48'h000000000009, 64'hAAAAAAAAAAAAAAAA, 8'h42,
                32'd9, STOCK_AAPL, 32'd9);
        dropTail(16);
        pushAdd(1'b1, 16'h0007, 48'h000000000123, 64'h0102030405060708, 8'h42,
                32'd7, STOCK_AAPL, 32'd77);
        playStream(1'b0);
        checkVal("sopabort_malformed", 64'(malCount - m0), 64'd1);
        checkVal("sopabort_pulses", 64'(validCount - v0), 64'd1);
        checkVal("sopabort_ref", orderRefOut, 64'h0102030405060708);
        checkVal("sopabort_locate", 64'(locateOut), 64'h0007);

        // packetLost mid-Add, then a non-sop stream that must be ignored
        v0 = validCount; m0 = malCount;
        pushAdd(1'b1, 16'h0011, 48'h000000000011, 64'h1111111111111111, 8'h42,
                32'd11, STOCK_AAPL, 32'd11);
        dropTail(20);
        playStream(1'b0);
        @(negedge clkIn);
        dataValidIn = 1'b1; dataIn = 8'h24; sopIn = 1'b0; packetLostIn = 1'b1;
        pushAdd(1'b0, 16'h0012, 48'h000000000012, 64'h2222222222222222, 8'h42,
                32'd12, STOCK_AAPL, 32'd12);
        playStream(1'b0);
        checkVal("lost_pulses", 64'(validCount - v0), 64'd0);
        checkVal("lost_malformed", 64'(malCount - m0), 64'd0);
        pushAdd(1'b1, 16'h0013, 48'h000000000013, 64'h3333333333333333, 8'h42,
                32'd13, STOCK_AAPL, 32'd13);
        playStream(1'b0);
        checkVal("lost_resume_pulses", 64'(validCount - v0), 64'd1);
        checkVal("lost_resume_ref", orderRefOut, 64'h3333333333333333);

        // Reset mid-message
        pushAdd(1'b1, 16'h0021, 48'h000000000021, 64'h4444444444444444, 8'h42,
                32'd21, STOCK_AAPL, 32'd21);
        dropTail(26);
        playStream(1'b0);
        @(negedge clkIn);
        rstBIn = 1'b0;
        #1;
        checkVal("midrst_ref", orderRefOut, 64'd0);
        checkVal("midrst_type", 64'(msgTypeOut), 64'd0);
        checkVal("midrst_price", 64'(priceOut), 64'd0);
        repeat (2) @(negedge clkIn);
        rstBIn = 1'b1;
        v0 = validCount;
        pushAdd(1'b0, 16'h0022, 48'h000000000022, 64'h5555555555555555, 8'h42,
                32'd22, STOCK_AAPL, 32'd22);
        playStream(1'b0);
        checkVal("postrst_nosop_pulses", 64'(validCount - v0), 64'd0);
        pushAdd(1'b1, 16'h0023, 48'h000000000023, 64'h6666666666666666, 8'h53,
                32'd23, STOCK_AAPL, 32'd23);
        playStream(1'b0);
        checkVal("postrst_pulses", 64'(validCount - v0), 64'd1);
        checkFields("postrst", 8'h41, 16'h0023, 48'h000000000023, 64'h6666666666666666, 1'b0,
                    32'd23, STOCK_AAPL, 32'd23);

        checkVal("no_overlap", 64'(bothCount), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
